// File: rtl/store_buffer.sv
// In-order store queue between MEM and DataMemory: accepts committed stores,
// drains them whenever the memory port is free, and forwards pending data to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        storeValid,
  input  logic [31:0] storeAddress,
  input  logic [31:0] storeData,
  input  logic [31:0] storeProgramCounter,
  output logic        storeReady,
  input  logic        loadValid,
  input  logic [31:0] loadAddress,
  output logic        loadHit,
  output logic [31:0] loadData,
  input  logic        memPortBusy,
  output logic        memWriteEnabled,
  output logic [31:0] memAddress,
  output logic [31:0] memDataWrite,
  output logic [31:0] memProgramCounter,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t            ent [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic              full, enq, drain;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign storeReady = !full;
  assign enq        = storeValid && storeReady;
  assign drain      = !empty && !memPortBusy;

  assign memWriteEnabled   = drain;
  assign memAddress        = {ent[head].addr, 2'b00};
  assign memDataWrite      = ent[head].data;
  assign memProgramCounter = ent[head].pc;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (enq) begin
        ent[tail] <= '{addr: storeAddress[31:2], data: storeData, pc: storeProgramCounter};
        tail      <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-slot age relative to head; a slot is live when its age is below count.
  logic [DEPTH-1:0][PW-1:0] slot_age;
  logic [DEPTH-1:0]         slot_match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_age[i]   = PW'(i) - head;
    assign slot_match[i] = ({1'b0, slot_age[i]} < count) &&
                           (ent[i].addr == loadAddress[31:2]);
  end

  logic          any_hit;
  logic [PW-1:0] best_age;
  logic [31:0]   best_data;

  always_comb begin
    any_hit   = 1'b0;
    best_age  = '0;
    best_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_match[i] && (!any_hit || slot_age[i] > best_age)) begin
        any_hit   = 1'b1;
        best_age  = slot_age[i];
        best_data = ent[i].data;
      end
    end
  end

  assign loadHit  = loadValid && any_hit;
  assign loadData = loadHit ? best_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model tracks pending stores and
// every cycle checks flags, forwarding and the drained entry.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        storeValid = 1'b0;
  logic [31:0] storeAddress = '0, storeData = '0, storeProgramCounter = '0;
  logic        storeReady;
  logic        loadValid = 1'b0;
  logic [31:0] loadAddress = '0;
  logic        loadHit;
  logic [31:0] loadData;
  logic        memPortBusy = 1'b0;
  logic        memWriteEnabled;
  logic [31:0] memAddress, memDataWrite, memProgramCounter;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .resetN(resetN),
    .storeValid(storeValid), .storeAddress(storeAddress), .storeData(storeData),
    .storeProgramCounter(storeProgramCounter), .storeReady(storeReady),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadHit(loadHit), .loadData(loadData),
    .memPortBusy(memPortBusy), .memWriteEnabled(memWriteEnabled), .memAddress(memAddress),
    .memDataWrite(memDataWrite), .memProgramCounter(memProgramCounter), .empty(empty)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] pc;
  } st_t;

  st_t         sb[$];
  logic        acc = 1'b0;
  logic        e_ready, e_hit, e_drain;
  logic [31:0] e_ld;

  // Model: outputs at negedge reflect state before the coming posedge.
  always @(negedge clock) begin
    if (!resetN) begin
      chk("rst_ready", storeReady, 1);
      chk("rst_empty", empty, 1);
      chk("rst_we", memWriteEnabled, 0);
      chk("rst_maddr", memAddress, 0);
      chk("rst_mdata", memDataWrite, 0);
      chk("rst_mpc", memProgramCounter, 0);
      chk("rst_hit", loadHit, 0);
      chk("rst_ldata", loadData, 0);
      sb.delete();
      acc = 1'b0;
    end else begin
      e_ready = (sb.size() != DEPTH);
      chk("ready", storeReady, e_ready);
      chk("empty", empty, sb.size() == 0);
      e_hit = 1'b0;
      e_ld  = '0;
      if (loadValid)
        foreach (sb[i])
          if (sb[i].a[31:2] == loadAddress[31:2]) begin
            e_hit = 1'b1;
            e_ld  = sb[i].d;
          end
      chk("fwd_hit", loadHit, e_hit);
      chk("fwd_data", loadData, e_ld);
      e_drain = (sb.size() != 0) && !memPortBusy;
      chk("drain_we", memWriteEnabled, e_drain);
      if (e_drain) begin
        chk("drain_addr", memAddress, {sb[0].a[31:2], 2'b00});
        chk("drain_data", memDataWrite, sb[0].d);
        chk("drain_pc", memProgramCounter, sb[0].pc);
        void'(sb.pop_front());
      end
      acc = storeValid && e_ready;
      if (acc) sb.push_back('{storeAddress, storeData, storeProgramCounter});
    end
  end

  logic [31:0] pcnt = 32'h0000_1000;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents a store until the model reports it accepted, then releases it.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    storeValid = 1'b1; storeAddress = a; storeData = d; storeProgramCounter = pcnt;
    pcnt += 4;
    for (int n = 0; n < 50; n++) begin
      @(posedge clock);
      if (acc) begin ok = 1; break; end
    end
    if (!ok) chk("store_timeout", 0, 1);
    #1;
    storeValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    resetN = 1'b1;
    cyc(1);

    // Single store reaches memory one cycle after enqueue.
    do_store(32'h10, 32'hAAAA_0001);
    @(negedge clock);
    chk("t1_we", memWriteEnabled, 1);
    chk("t1_addr", memAddress, 32'h10);
    chk("t1_data", memDataWrite, 32'hAAAA_0001);
    cyc(1);
    @(negedge clock);
    chk("t1_empty", empty, 1);
    cyc(1);

    // Fill while busy, 5th stalls, then in-order drain.
    memPortBusy = 1'b1;
    do_store(32'h0, 32'h100);
    do_store(32'h4, 32'h104);
    do_store(32'h8, 32'h108);
    do_store(32'hC, 32'h10C);
    storeValid = 1'b1; storeAddress = 32'h50; storeData = 32'h150;
    cyc(3);
    chk("t2_full_ready", storeReady, 0);
    chk("t2_full_we", memWriteEnabled, 0);
    storeValid = 1'b0;
    memPortBusy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2_order", memAddress, 32'(k * 4));
      chk("t2_we", memWriteEnabled, 1);
      cyc(1);
    end
    @(negedge clock);
    chk("t2_empty", empty, 1);
    cyc(1);

    // Forwarding picks youngest matching entry; low address bits ignored.
    memPortBusy = 1'b1;
    do_store(32'h20, 32'h1);
    do_store(32'h21, 32'h2);
    loadValid = 1'b1; loadAddress = 32'h22;
    @(negedge clock);
    chk("t3_hit", loadHit, 1);
    chk("t3_data", loadData, 32'h2);
    cyc(1);
    loadAddress = 32'h24;
    @(negedge clock);
    chk("t3_miss", loadHit, 0);
    chk("t3_miss_data", loadData, 0);
    cyc(1);
    loadValid = 1'b0;
    memPortBusy = 1'b0;
    cyc(3);

    // Full buffer: a drain in the same cycle does not open the door.
    memPortBusy = 1'b1;
    do_store(32'h30, 32'h30);
    do_store(32'h34, 32'h34);
    do_store(32'h38, 32'h38);
    do_store(32'h3C, 32'h3C);
    memPortBusy = 1'b0;
    storeValid = 1'b1; storeAddress = 32'h40; storeData = 32'h40; storeProgramCounter = pcnt;
    @(negedge clock);
    chk("t4_ready_drain", storeReady, 0);
    chk("t4_we", memWriteEnabled, 1);
    cyc(1);
    memPortBusy = 1'b1;
    @(negedge clock);
    chk("t4_ready_retry", storeReady, 1);
    cyc(1);
    storeValid = 1'b0;
    @(negedge clock);
    chk("t4_full_again", storeReady, 0);
    cyc(1);
    memPortBusy = 1'b0;
    cyc(6);

    // Sustained enqueue+drain at count=1 wraps both pointers.
    memPortBusy = 1'b1;
    do_store(32'h200, 32'hB000_0000);
    memPortBusy = 1'b0;
    for (int k = 1; k <= 10; k++) do_store(32'h200 + 32'(k * 4), 32'hB000_0000 + 32'(k));
    memPortBusy = 1'b1;
    @(negedge clock);
    chk("t5_not_empty", empty, 0);
    chk("t5_ready", storeReady, 1);
    cyc(1);
    memPortBusy = 1'b0;
    cyc(2);

    // Reset mid-drain discards pending stores immediately.
    memPortBusy = 1'b1;
    do_store(32'h300, 32'h3);
    do_store(32'h304, 32'h4);
    do_store(32'h308, 32'h5);
    memPortBusy = 1'b0;
    #2;
    chk("t6_pre_we", memWriteEnabled, 1);
    resetN = 1'b0;
    #1;
    chk("t6_rst_we", memWriteEnabled, 0);
    chk("t6_rst_empty", empty, 1);
    cyc(2);
    resetN = 1'b1;
    cyc(4);
    chk("t6_post_empty", empty, 1);
    chk("t6_post_we", memWriteEnabled, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
